// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame states, mouse byte-0 layout and packet decode
package ps2_pkg;
  localparam int PS2_FRAME_BITS = 11;
  localparam int B0_L  = 0;
  localparam int B0_R  = 1;
  localparam int B0_AL = 3;
  localparam int B0_XS = 4;
  localparam int B0_YS = 5;
  localparam int B0_XO = 6;
  localparam int B0_YO = 7;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_state_t;
  typedef struct packed {
    logic [1:0] buttons;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] ovf;
  } mouse_packet_t;
  function automatic mouse_packet_t decode(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    decode.buttons = {b0[B0_R], b0[B0_L]};
    decode.dx      = {b0[B0_XS], b1};
    decode.dy      = {b0[B0_YS], b2};
    decode.ovf     = {b0[B0_YO], b0[B0_XO]};
  endfunction
endpackage

// File: rtl/ps2_mouse_rx_if.sv
// ps2_mouse_rx_if: cursor/button/event bundle from the mouse receiver to game logic
interface ps2_mouse_rx_if #(parameter int XW = 10, parameter int YW = 9);
  logic [XW-1:0] cursor_x_o;
  logic [YW-1:0] cursor_y_o;
  logic          left_btn_o;
  logic          right_btn_o;
  logic          packet_valid_o;
  logic          frame_err_o;
  modport master(output cursor_x_o, cursor_y_o, left_btn_o, right_btn_o, packet_valid_o, frame_err_o);
  modport slave(input cursor_x_o, cursor_y_o, left_btn_o, right_btn_o, packet_valid_o, frame_err_o);
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronise and filter PS/2 lines, receive 11-bit frames, time out stalls
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       run_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o,
  output logic       busy_o,
  output logic       timeout_o
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  frame_state_t  state_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          par_q, bv_q, err_q, tmo_q;
  logic [TW-1:0] tcnt_q;
  logic          clk_s, dat_s, fall, tmo;
  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  // the edge is taken in the very cycle the filter accepts the low level
  assign fall = filt_q & ~clk_s & (fcnt_q == FW'(FILTER_LEN - 1));
  assign tmo  = run_i & ~fall & (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign byte_o       = sh_q;
  assign byte_valid_o = bv_q;
  assign err_o        = err_q;
  assign timeout_o    = tmo_q;
  assign busy_o       = state_q != ST_IDLE;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= ST_IDLE;
      bit_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      bv_q       <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      if (clk_s == filt_q) fcnt_q <= '0;
      else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= clk_s;
        fcnt_q <= '0;
      end else fcnt_q <= fcnt_q + 1'b1;
      bv_q   <= 1'b0;
      err_q  <= 1'b0;
      tmo_q  <= 1'b0;
      tcnt_q <= (fall || !run_i || tmo) ? '0 : tcnt_q + 1'b1;
      if (tmo) begin
        state_q <= ST_IDLE;
        tmo_q   <= 1'b1;
        err_q   <= state_q != ST_IDLE;
      end else if (fall) begin
        case (state_q)
          ST_IDLE: if (!dat_s) begin
            state_q <= ST_DATA;
            bit_q   <= '0;
            par_q   <= 1'b0;
          end
          ST_DATA: begin
            sh_q    <= {dat_s, sh_q[7:1]};
            par_q   <= par_q ^ dat_s;
            bit_q   <= bit_q + 1'b1;
            state_q <= (bit_q == 3'd7) ? ST_PARITY : ST_DATA;
          end
          ST_PARITY: begin
            par_q   <= par_q ^ dat_s;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            bv_q    <= dat_s & par_q;
            err_q   <= ~(dat_s & par_q);
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: assemble 3-byte PS/2 mouse packets into a clamped absolute cursor and buttons
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  ps2_mouse_rx_if.master mif
);
  localparam int XW = $clog2(ACTIVE_COLUMNS);
  localparam int YW = $clog2(ACTIVE_ROWS);
  logic [7:0]          rx_byte;
  logic                rx_bv, rx_err, rx_busy, rx_tmo;
  logic [1:0]          idx_q;
  logic [7:0]          b0_q, b1_q;
  logic [XW-1:0]       x_q, xc;
  logic [YW-1:0]       y_q, yc;
  logic                l_q, r_q, pv_q;
  logic signed [XW+1:0] sx;
  logic signed [YW+1:0] sy;
  mouse_packet_t       pkt;
  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .run_i       (rx_busy || idx_q != 2'd0),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_bv),
    .err_o       (rx_err),
    .busy_o      (rx_busy),
    .timeout_o   (rx_tmo)
  );
  assign pkt = decode(b0_q, b1_q, rx_byte);
  assign sx  = $signed({2'b00, x_q}) + $signed({{(XW - 7){pkt.dx[8]}}, pkt.dx});
  assign sy  = $signed({2'b00, y_q}) - $signed({{(YW - 7){pkt.dy[8]}}, pkt.dy});
  assign xc  = sx[XW+1] ? '0 : (sx > $signed((XW + 2)'(ACTIVE_COLUMNS - 1))) ? XW'(ACTIVE_COLUMNS - 1) : sx[XW-1:0];
  assign yc  = sy[YW+1] ? '0 : (sy > $signed((YW + 2)'(ACTIVE_ROWS - 1))) ? YW'(ACTIVE_ROWS - 1) : sy[YW-1:0];
  assign mif.cursor_x_o     = x_q;
  assign mif.cursor_y_o     = y_q;
  assign mif.left_btn_o     = l_q;
  assign mif.right_btn_o    = r_q;
  assign mif.packet_valid_o = pv_q;
  assign mif.frame_err_o    = rx_err;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q <= '0;
      b0_q  <= '0;
      b1_q  <= '0;
      x_q   <= XW'(ACTIVE_COLUMNS / 2);
      y_q   <= YW'(ACTIVE_ROWS / 2);
      l_q   <= 1'b0;
      r_q   <= 1'b0;
      pv_q  <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      if (rx_err || rx_tmo) idx_q <= '0;
      else if (rx_bv) begin
        case (idx_q)
          2'd0: if (rx_byte[B0_AL]) begin
            b0_q  <= rx_byte;
            idx_q <= 2'd1;
          end
          2'd1: begin
            b1_q  <= rx_byte;
            idx_q <= 2'd2;
          end
          2'd2: begin
            idx_q <= '0;
            pv_q  <= 1'b1;
            l_q   <= pkt.buttons[0];
            r_q   <= pkt.buttons[1];
            if (!pkt.ovf[0]) x_q <= xc;
            if (!pkt.ovf[1]) y_q <= yc;
          end
          default: idx_q <= '0;
        endcase
      end
    end
  end
endmodule
